// File: rtl/ahb_slave_if_if.sv
// Bus bundle between the AHB fabric and the AHB-side front end of the
// AHB-to-APB bridge.
//   slave  modport: AHB address/data-phase inputs in; strobe, select,
//                   delay-line and error outputs out.
//   master modport: the mirror image, for whatever drives the bus.
interface ahb_slave_if_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              hwrite;
  logic              hreadyin;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;

  logic              valid;
  logic [2:0]        tempselx;
  logic [ADDR_W-1:0] haddr1;
  logic [ADDR_W-1:0] haddr2;
  logic [ADDR_W-1:0] haddr3;
  logic [ADDR_W-1:0] haddr4;
  logic [DATA_W-1:0] hwdata1;
  logic [DATA_W-1:0] hwdata2;
  logic [DATA_W-1:0] hwdata3;
  logic [DATA_W-1:0] hwdata4;
  logic              hwritereg;
  logic              hwritereg1;
  logic              addr_err;

  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata,
    output valid, tempselx,
    output haddr1, haddr2, haddr3, haddr4,
    output hwdata1, hwdata2, hwdata3, hwdata4,
    output hwritereg, hwritereg1, addr_err
  );

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata,
    input  valid, tempselx,
    input  haddr1, haddr2, haddr3, haddr4,
    input  hwdata1, hwdata2, hwdata3, hwdata4,
    input  hwritereg, hwritereg1, addr_err
  );

endinterface

// File: rtl/ahb_slave_if.sv
// AHB-side front end of the AHB-to-APB bridge.
// Qualifies AHB transfers into a zero-latency valid strobe, decodes a one-hot
// APB slave select, flags live transfers to unmapped addresses, and provides
// free-running 1..4 cycle delay lines of haddr/hwdata and 1..2 of hwrite for
// the downstream APB controller.
// Ports:
//   hclk     bridge clock, rising edge
//   hresetn  asynchronous active-low reset
//   bus      ahb_slave_if_if.slave (inputs hwrite/hreadyin/htrans/haddr/hwdata;
//            outputs valid/tempselx (combinational), haddr1..4, hwdata1..4,
//            hwritereg, hwritereg1, addr_err (registered))
module ahb_slave_if #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SLV0_BASE = ADDR_W'(32'h8000_0000),
  parameter logic [ADDR_W-1:0] SLV1_BASE = ADDR_W'(32'h8400_0000),
  parameter logic [ADDR_W-1:0] SLV2_BASE = ADDR_W'(32'h8800_0000),
  parameter logic [ADDR_W-1:0] SLV_SIZE  = ADDR_W'(32'h0400_0000)
) (
  input  logic           hclk,
  input  logic           hresetn,
  ahb_slave_if_if.slave  bus
);

  localparam int unsigned NSTG = 4;

  // Offset form (a - base < size) keeps the window test free of wrap-around
  // even when base + size overflows ADDR_W.
  function automatic logic in_win(input logic [ADDR_W-1:0] a,
                                  input logic [ADDR_W-1:0] base);
    return (a >= base) && ((a - base) < SLV_SIZE);
  endfunction

  logic [2:0] hit_c;
  logic [2:0] sel_c;
  logic       live_c;

  logic [NSTG-1:0][ADDR_W-1:0] haddr_d,  haddr_q;
  logic [NSTG-1:0][DATA_W-1:0] hwdata_d, hwdata_q;
  logic [1:0]                  hwrite_d, hwrite_q;
  logic                        addr_err_d, addr_err_q;

  // Address decode and transfer qualification; lowest index wins on overlap.
  always_comb begin
    hit_c  = 3'b000;
    sel_c  = 3'b000;
    live_c = bus.hreadyin && bus.htrans[1];
    hit_c[0] = in_win(bus.haddr, SLV0_BASE);
    hit_c[1] = in_win(bus.haddr, SLV1_BASE);
    hit_c[2] = in_win(bus.haddr, SLV2_BASE);
    if (hit_c[0]) begin
      sel_c = 3'b001;
    end else if (hit_c[1]) begin
      sel_c = 3'b010;
    end else if (hit_c[2]) begin
      sel_c = 3'b100;
    end
  end

  // Combinational outputs are held low while reset is asserted.
  assign bus.tempselx = hresetn ? sel_c : 3'b000;
  assign bus.valid    = hresetn && live_c && (|hit_c);

  // Next-state: delay lines shift every edge, independent of ready/valid.
  always_comb begin
    haddr_d    = {haddr_q[NSTG-2:0], bus.haddr};
    hwdata_d   = {hwdata_q[NSTG-2:0], bus.hwdata};
    hwrite_d   = {hwrite_q[0], bus.hwrite};
    addr_err_d = live_c && !(|hit_c);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr_q    <= '0;
      hwdata_q   <= '0;
      hwrite_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      haddr_q    <= haddr_d;
      hwdata_q   <= hwdata_d;
      hwrite_q   <= hwrite_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.haddr1     = haddr_q[0];
  assign bus.haddr2     = haddr_q[1];
  assign bus.haddr3     = haddr_q[2];
  assign bus.haddr4     = haddr_q[3];
  assign bus.hwdata1    = hwdata_q[0];
  assign bus.hwdata2    = hwdata_q[1];
  assign bus.hwdata3    = hwdata_q[2];
  assign bus.hwdata4    = hwdata_q[3];
  assign bus.hwritereg  = hwrite_q[0];
  assign bus.hwritereg1 = hwrite_q[1];
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed steps drive one address
// phase per cycle; registered expectations go into a due-cycle scoreboard and
// are compared once the DUT edge they belong to has occurred.
module tb_ahb_slave_if;

  logic hclk;
  logic hresetn;

  ahb_slave_if_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_slave_if dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  localparam int S_A1  = 0;
  localparam int S_D1  = 4;
  localparam int S_W1  = 8;
  localparam int S_W2  = 9;
  localparam int S_ERR = 10;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t sb[$];
  int  cyc;
  int  vectors;
  int  miscompares;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:  return bus.haddr1;
      1:  return bus.haddr2;
      2:  return bus.haddr3;
      3:  return bus.haddr4;
      4:  return bus.hwdata1;
      5:  return bus.hwdata2;
      6:  return bus.hwdata3;
      7:  return bus.hwdata4;
      8:  return 32'(bus.hwritereg);
      9:  return 32'(bus.hwritereg1);
      default: return 32'(bus.addr_err);
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0, 1, 2, 3: return $sformatf("haddr%0d", sel + 1);
      4, 5, 6, 7: return $sformatf("hwdata%0d", sel - 3);
      8:          return "hwritereg";
      9:          return "hwritereg1";
      default:    return "addr_err";
    endcase
  endfunction

  task automatic check(input logic [31:0] o, input logic [31:0] e, input string tag);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input int due, input int sel, input logic [31:0] e, input string tag);
    sb_t it;
    it.due = due;
    it.sel = sel;
    it.exp = e;
    it.tag = $sformatf("%s.%s", tag, sel_name(sel));
    sb.push_back(it);
  endtask

  task automatic check_due();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(obs(sb[i].sel), sb[i].exp, sb[i].tag);
        sb.delete(i);
      end
    end
  endtask

  // Reference decode written directly from the slave windows.
  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction

  // One address phase: drive at negedge, check comb outputs, queue the
  // registered expectations, then resolve whatever is due at this edge.
  task automatic drive(input string tag, input logic [1:0] tr, input logic rdy,
                       input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic ev, input logic [2:0] es, input logic ee);
    @(negedge hclk);
    bus.htrans   = tr;
    bus.hreadyin = rdy;
    bus.hwrite   = wr;
    bus.haddr    = a;
    bus.hwdata   = d;
    #1;
    check(32'(bus.valid), 32'(ev), {tag, ".valid"});
    check(32'(bus.tempselx), 32'(es), {tag, ".tempselx"});
    for (int k = 0; k < 4; k++) begin
      push(cyc + 1 + k, S_A1 + k, a, tag);
      push(cyc + 1 + k, S_D1 + k, d, tag);
    end
    push(cyc + 1, S_W1, 32'(wr), tag);
    push(cyc + 2, S_W2, 32'(wr), tag);
    push(cyc + 1, S_ERR, 32'(ee), tag);
    @(posedge hclk);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s <= S_ERR; s++) check(obs(s), 32'h0, {tag, ".", sel_name(s)});
    check(32'(bus.valid), 32'h0, {tag, ".valid"});
    check(32'(bus.tempselx), 32'h0, {tag, ".tempselx"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [1:0]  rt;
    logic        rr;
    logic [2:0]  rs;
    logic        rlive;

    cyc = 0;
    vectors = 0;
    miscompares = 0;

    // Reset with a live mapped transfer on the bus: everything must read 0.
    hresetn      = 1'b0;
    bus.htrans   = 2'b10;
    bus.hreadyin = 1'b1;
    bus.hwrite   = 1'b1;
    bus.haddr    = 32'h8000_0000;
    bus.hwdata   = 32'hDEAD_BEEF;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;

    // Single write followed by its data phase.
    drive("wr1",    2'b10, 1'b1, 1'b1, 32'h8000_0010, 32'h0000_0000, 1'b1, 3'b001, 1'b0);
    drive("wr1_dp", 2'b00, 1'b1, 1'b0, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 3'b000, 1'b0);
    drive("idle0",  2'b00, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 3'b000, 1'b0);

    // Window boundaries.
    drive("b_s0_top", 2'b10, 1'b1, 1'b0, 32'h83FF_FFFF, 32'h1111_0000, 1'b1, 3'b001, 1'b0);
    drive("b_s1_bot", 2'b10, 1'b1, 1'b1, 32'h8400_0000, 32'h1111_0001, 1'b1, 3'b010, 1'b0);
    drive("b_s2_top", 2'b10, 1'b1, 1'b0, 32'h8BFF_FFFF, 32'h1111_0002, 1'b1, 3'b100, 1'b0);
    drive("b_above",  2'b10, 1'b1, 1'b1, 32'h8C00_0000, 32'h1111_0003, 1'b0, 3'b000, 1'b1);
    drive("idle1",    2'b00, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 3'b000, 1'b0);
    drive("b_below",  2'b10, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1111_0004, 1'b0, 3'b000, 1'b1);
    drive("b_below2", 2'b11, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1111_0005, 1'b0, 3'b000, 1'b1);
    drive("idle2",    2'b00, 1'b1, 1'b0, 32'h8C00_0000, 32'h0000_0000, 1'b0, 3'b000, 1'b0);

    // Qualification: IDLE, BUSY, NONSEQ-not-ready never live.
    drive("q_idle",   2'b00, 1'b1, 1'b0, 32'h8400_0040, 32'h2222_0000, 1'b0, 3'b010, 1'b0);
    drive("q_busy",   2'b01, 1'b1, 1'b0, 32'h8400_0040, 32'h2222_0001, 1'b0, 3'b010, 1'b0);
    drive("q_nrdy",   2'b10, 1'b0, 1'b0, 32'h8400_0040, 32'h2222_0002, 1'b0, 3'b010, 1'b0);
    drive("q_seq",    2'b11, 1'b1, 1'b0, 32'h8400_0040, 32'h2222_0003, 1'b1, 3'b010, 1'b0);
    drive("q_nrdy_u", 2'b10, 1'b0, 1'b0, 32'h9000_0000, 32'h2222_0004, 1'b0, 3'b000, 1'b0);

    // Four-beat SEQ write burst.
    drive("burst0", 2'b10, 1'b1, 1'b1, 32'h8800_0000, 32'hB000_0000, 1'b1, 3'b100, 1'b0);
    drive("burst1", 2'b11, 1'b1, 1'b1, 32'h8800_0004, 32'hB000_0001, 1'b1, 3'b100, 1'b0);
    drive("burst2", 2'b11, 1'b1, 1'b1, 32'h8800_0008, 32'hB000_0002, 1'b1, 3'b100, 1'b0);
    drive("burst3", 2'b11, 1'b1, 1'b1, 32'h8800_000C, 32'hB000_0003, 1'b1, 3'b100, 1'b0);
    check(bus.haddr4, 32'h8800_0000, "burst_end.haddr4");
    check(bus.haddr3, 32'h8800_0004, "burst_end.haddr3");
    check(bus.haddr2, 32'h8800_0008, "burst_end.haddr2");
    check(bus.haddr1, 32'h8800_000C, "burst_end.haddr1");
    check(bus.hwdata4, 32'hB000_0000, "burst_end.hwdata4");
    check(bus.hwdata1, 32'hB000_0003, "burst_end.hwdata1");

    // Async reset mid-burst, between edges.
    drive("mb0", 2'b10, 1'b1, 1'b1, 32'h8000_0100, 32'hC000_0000, 1'b1, 3'b001, 1'b0);
    drive("mb1", 2'b11, 1'b1, 1'b1, 32'h8000_0104, 32'hC000_0001, 1'b1, 3'b001, 1'b0);
    #1;
    hresetn = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    // Stages that predate the reset must stay 0 as the line refills.
    for (int k = 1; k < 4; k++) begin
      for (int j = 1; j <= k; j++) begin
        push(cyc + j, S_A1 + k, 32'h0, "postrst");
        push(cyc + j, S_D1 + k, 32'h0, "postrst");
      end
    end
    push(cyc + 1, S_W2, 32'h0, "postrst");
    #1;
    hresetn = 1'b1;
    drive("mb2", 2'b11, 1'b1, 1'b1, 32'h8000_0108, 32'hC000_0002, 1'b1, 3'b001, 1'b0);
    drive("mb3", 2'b11, 1'b1, 1'b1, 32'h8000_010C, 32'hC000_0003, 1'b1, 3'b001, 1'b0);

    // Random traffic around the mapped region.
    for (int n = 0; n < 24; n++) begin
      ra = 32'h7C00_0000 + 32'($urandom_range(32'h1400_0000));
      rt = 2'($urandom_range(3));
      rr = 1'($urandom_range(1));
      rs = ref_sel(ra);
      rlive = rr && rt[1];
      drive($sformatf("rnd%0d", n), rt, rr, 1'($urandom_range(1)), ra, $urandom,
            rlive && (rs != 3'b000), rs, rlive && (rs == 3'b000));
    end

    // Drain the scoreboard.
    repeat (4) drive("flush", 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
